// File: rtl/char_sweep_sequencer_if.sv
// Signal bundle between the config block, the ASIC pins and the sweep sequencer.
// master drives control/config/ASIC inputs; slave is the sequencer side.
interface char_sweep_sequencer_if #(
  parameter int unsigned SETTLE_WIDTH   = 32,
  parameter int unsigned INTERVAL_WIDTH = 16
);
  logic                      start;
  logic                      abort;
  logic [SETTLE_WIDTH-1:0]   settle_cycles;
  logic [7:0]                num_samples;
  logic [INTERVAL_WIDTH-1:0] sample_interval;
  logic [1:0]                manual_char_select;
  logic [1:0]                network_output;
  logic [1:0]                char_select;
  logic                      busy;
  logic                      done;
  logic                      result_valid;
  logic [1:0]                result_char;
  logic [1:0]                result_class;
  logic [7:0]                result_votes;
  logic [3:0]                match_mask;

  modport master (
    output start, abort, settle_cycles, num_samples, sample_interval,
           manual_char_select, network_output,
    input  char_select, busy, done, result_valid, result_char,
           result_class, result_votes, match_mask
  );

  modport slave (
    input  start, abort, settle_cycles, num_samples, sample_interval,
           manual_char_select, network_output,
    output char_select, busy, done, result_valid, result_char,
           result_class, result_votes, match_mask
  );
endinterface

// File: rtl/char_sweep_sequencer.sv
// Sweeps char_select over all four characters, majority-votes the synchronized
// network_output after each settle window and reports per-character results.
module char_sweep_sequencer #(
  parameter int unsigned SETTLE_WIDTH   = 32,
  parameter int unsigned INTERVAL_WIDTH = 16
) (
  input logic                   S_AXI_ACLK,
  input logic                   Local_Reset,
  char_sweep_sequencer_if.slave bus
);
  localparam int unsigned VOTE_WIDTH = 8;
  localparam int unsigned NUM_CHARS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_WAIT,
    ST_DECIDE
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                sync1_q, sync2_q;
  logic [SETTLE_WIDTH-1:0]   settle_load_q, settle_cnt_q;
  logic [SETTLE_WIDTH-1:0]   settle_init_c;
  logic [INTERVAL_WIDTH-1:0] interval_q, wait_cnt_q;
  logic [VOTE_WIDTH-1:0]     num_eff_q, smp_cnt_q;
  logic [VOTE_WIDTH-1:0]     votes_q [NUM_CHARS];
  logic [1:0]                char_q;
  logic                      busy_q, done_q, result_valid_q;
  logic [1:0]                result_char_q, result_class_q;
  logic [VOTE_WIDTH-1:0]     result_votes_q;
  logic [NUM_CHARS-1:0]      match_mask_q;

  logic                      accept_c, sample_c, decide_c, last_sample_c;
  logic [1:0]                winner_c;
  logic [VOTE_WIDTH-1:0]     winner_votes_c;

  // Two-flop synchronizer for the asynchronous ASIC classification
  always_ff @(posedge S_AXI_ACLK) begin
    if (Local_Reset) begin
      sync1_q <= 2'd0;
      sync2_q <= 2'd0;
    end else begin
      sync1_q <= bus.network_output;
      sync2_q <= sync1_q;
    end
  end

  // Counter preload so SETTLE lasts max(settle_cycles,1) cycles
  assign settle_init_c = (bus.settle_cycles == '0) ? '0
                                                    : bus.settle_cycles - SETTLE_WIDTH'(1);
  assign last_sample_c = (smp_cnt_q + VOTE_WIDTH'(1)) == num_eff_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (Local_Reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start && !bus.abort) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (last_sample_c)           state_d = ST_DECIDE;
        else if (interval_q == '0)   state_d = ST_SAMPLE;
        else                         state_d = ST_WAIT;
      end
      ST_WAIT:   if (wait_cnt_q == '0) state_d = ST_SAMPLE;
      ST_DECIDE: state_d = (char_q == 2'd3) ? ST_IDLE : ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && bus.abort) state_d = ST_IDLE;
  end

  // Abort suppresses any sample or decision in the cycle it arrives
  always_comb begin
    accept_c = 1'b0;
    sample_c = 1'b0;
    decide_c = 1'b0;
    if (state_q == ST_IDLE) accept_c = bus.start && !bus.abort;
    if (state_q == ST_SAMPLE) sample_c = !bus.abort;
    if (state_q == ST_DECIDE) decide_c = !bus.abort;
  end

  // Strict '>' keeps the lowest class index on ties
  always_comb begin
    winner_c       = 2'd0;
    winner_votes_c = votes_q[0];
    for (int unsigned i = 1; i < NUM_CHARS; i++) begin
      if (votes_q[i] > winner_votes_c) begin
        winner_c       = 2'(i);
        winner_votes_c = votes_q[i];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (Local_Reset) begin
      settle_load_q  <= '0;
      settle_cnt_q   <= '0;
      interval_q     <= '0;
      wait_cnt_q     <= '0;
      num_eff_q      <= VOTE_WIDTH'(1);
      smp_cnt_q      <= '0;
      for (int unsigned i = 0; i < NUM_CHARS; i++) votes_q[i] <= '0;
      char_q         <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_char_q  <= 2'd0;
      result_class_q <= 2'd0;
      result_votes_q <= '0;
      match_mask_q   <= '0;
    end else begin
      result_valid_q <= 1'b0;
      busy_q         <= (state_d != ST_IDLE);

      if (accept_c) begin
        settle_load_q <= settle_init_c;
        settle_cnt_q  <= settle_init_c;
        interval_q    <= bus.sample_interval;
        num_eff_q     <= (bus.num_samples == '0) ? VOTE_WIDTH'(1) : bus.num_samples;
        smp_cnt_q     <= '0;
        for (int unsigned i = 0; i < NUM_CHARS; i++) votes_q[i] <= '0;
        char_q        <= 2'd0;
        done_q        <= 1'b0;
        match_mask_q  <= '0;
      end

      if (state_q == ST_SETTLE && settle_cnt_q != '0)
        settle_cnt_q <= settle_cnt_q - SETTLE_WIDTH'(1);

      if (state_q == ST_WAIT && wait_cnt_q != '0)
        wait_cnt_q <= wait_cnt_q - INTERVAL_WIDTH'(1);

      if (sample_c) begin
        votes_q[sync2_q] <= votes_q[sync2_q] + VOTE_WIDTH'(1);
        smp_cnt_q        <= smp_cnt_q + VOTE_WIDTH'(1);
        wait_cnt_q       <= interval_q - INTERVAL_WIDTH'(1);
      end

      if (decide_c) begin
        result_valid_q <= 1'b1;
        result_char_q  <= char_q;
        result_class_q <= winner_c;
        result_votes_q <= winner_votes_c;
        if (winner_c == char_q) match_mask_q[char_q] <= 1'b1;
        smp_cnt_q <= '0;
        for (int unsigned i = 0; i < NUM_CHARS; i++) votes_q[i] <= '0;
        if (char_q == 2'd3) begin
          done_q <= 1'b1;
        end else begin
          char_q       <= char_q + 2'd1;
          settle_cnt_q <= settle_load_q;
        end
      end

      if (bus.abort) done_q <= 1'b0;
    end
  end

  // Select is muxed from registered state only, so the pin changes on edges
  assign bus.char_select  = busy_q ? char_q : bus.manual_char_select;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_char  = result_char_q;
  assign bus.result_class = result_class_q;
  assign bus.result_votes = result_votes_q;
  assign bus.match_mask   = match_mask_q;
endmodule

// File: tb/tb_char_sweep_sequencer.sv
// Bench for char_sweep_sequencer: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized sweeps.
module tb_char_sweep_sequencer;
  localparam int unsigned SW = 32;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_sweep_sequencer_if #(.SETTLE_WIDTH(SW), .INTERVAL_WIDTH(IW)) bus ();

  char_sweep_sequencer #(.SETTLE_WIDTH(SW), .INTERVAL_WIDTH(IW)) dut (
    .S_AXI_ACLK (clk),
    .Local_Reset(rst),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Reference model state
  bit         m_active, m_done, m_rv;
  bit [3:0]   m_mask;
  int         m_ch, m_base, m_S, m_N, m_I;
  int         m_rchar, m_rclass, m_rvotes;
  int         m_votes [4];
  logic [1:0] hist [0:65535];

  typedef struct {
    int cyc;
    int ch;
    int cls;
    int votes;
    int busy;
    int done;
  } res_t;
  res_t rlog[$];

  int         net_mode = 0;
  logic [1:0] net_fixed = 2'd0;
  bit         alt = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a character starting at cycle b holds S settle cycles, then
  // N samples spaced I+1 apart, then one decide cycle; samples see net two cycles back.
  task automatic model_step();
    int rel, per, best;
    hist[cyc] = bus.network_output;
    m_rv = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_mask = 4'd0; m_ch = 0;
      m_rchar = 0; m_rclass = 0; m_rvotes = 0;
      return;
    end
    if (!m_active) begin
      if (bus.abort) m_done = 1'b0;
      else if (bus.start) begin
        m_S = (bus.settle_cycles == 0) ? 1 : int'(bus.settle_cycles);
        m_N = (bus.num_samples == 0) ? 1 : int'(bus.num_samples);
        m_I = int'(bus.sample_interval);
        m_active = 1'b1; m_base = cyc + 1; m_ch = 0; m_mask = 4'd0; m_done = 1'b0;
        for (int i = 0; i < 4; i++) m_votes[i] = 0;
        acc_cyc = cyc;
      end
    end else if (bus.abort) begin
      m_active = 1'b0; m_done = 1'b0;
    end else begin
      rel = cyc - m_base;
      per = m_I + 1;
      if (rel >= m_S && (rel - m_S) % per == 0 && (rel - m_S) / per < m_N)
        m_votes[hist[cyc-2]]++;
      if (rel == m_S + (m_N - 1) * per + 1) begin
        best = 0;
        for (int c = 1; c < 4; c++) if (m_votes[c] > m_votes[best]) best = c;
        m_rv = 1'b1; m_rchar = m_ch; m_rclass = best; m_rvotes = m_votes[best];
        if (best == m_ch) m_mask[m_ch] = 1'b1;
        if (m_ch == 3) begin
          m_active = 1'b0; m_done = 1'b1;
        end else begin
          m_ch++; m_base = cyc + 1;
          for (int i = 0; i < 4; i++) m_votes[i] = 0;
        end
      end
    end
  endtask

  // Per-cycle compare against the model, just after each active edge
  always @(posedge clk) begin
    model_step();
    cyc++;
    #1;
    chk("busy", bus.busy, m_active);
    chk("done", bus.done, m_done);
    chk("result_valid", bus.result_valid, m_rv);
    chk("char_select", bus.char_select, m_active ? m_ch : int'(bus.manual_char_select));
    chk("match_mask", bus.match_mask, m_mask);
    chk("result_char", bus.result_char, m_rchar);
    chk("result_class", bus.result_class, m_rclass);
    chk("result_votes", bus.result_votes, m_rvotes);
    if (bus.result_valid)
      rlog.push_back('{cyc, int'(bus.result_char), int'(bus.result_class),
                       int'(bus.result_votes), int'(bus.busy), int'(bus.done)});
  end

  // ASIC output emulation
  always @(negedge clk) begin
    case (net_mode)
      0:       bus.network_output = bus.char_select;
      1:       bus.network_output = net_fixed;
      2:       begin bus.network_output = alt ? 2'd1 : 2'd2; alt = ~alt; end
      default: bus.network_output = 2'($urandom_range(0, 3));
    endcase
  end

  task automatic cfg(input int s, input int n, input int iv);
    bus.settle_cycles   = SW'(s);
    bus.num_samples     = 8'(n);
    bus.sample_interval = IW'(iv);
  endtask

  task automatic pulse_start();
    rlog.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    if (bus.busy) begin
      n_checks++; n_err++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", bus.busy, budget);
    end
  endtask

  task automatic goto_cycle(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin @(negedge clk); n++; end
    if (cyc != target) begin
      n_checks++; n_err++;
      $display("FAIL goto_cycle: at cycle %0d, required %0d", cyc, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.manual_char_select = 2'd0;
    bus.network_output = 2'd0;
    cfg(2, 3, 0);
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_mask", bus.match_mask, 0);
    rst = 1'b0;
    @(negedge clk);

    // Loopback, settle 2, 3 samples
    net_mode = 0;
    pulse_start();
    wait_idle(200);
    chk("t1_count", rlog.size(), 4);
    for (int i = 0; i < rlog.size() && i < 4; i++) begin
      chk("t1_rv_cycle", rlog[i].cyc - acc_cyc, 7 + 6 * i);
      chk("t1_char", rlog[i].ch, i);
      chk("t1_votes", rlog[i].votes, 3);
    end
    if (rlog.size() == 4) begin
      chk("t1_final_busy", rlog[3].busy, 0);
      chk("t1_final_done", rlog[3].done, 1);
    end
    chk("t1_mask", bus.match_mask, 4'b1111);

    // Fixed class 2
    net_mode = 1; net_fixed = 2'd2;
    repeat (3) @(negedge clk);
    pulse_start();
    wait_idle(200);
    chk("t2_count", rlog.size(), 4);
    for (int i = 0; i < rlog.size() && i < 4; i++) chk("t2_class", rlog[i].cls, 2);
    chk("t2_mask", bus.match_mask, 4'b0100);

    // Alternating 1/2 over 4 samples: tie to class 1
    net_mode = 2; cfg(2, 4, 0);
    pulse_start();
    wait_idle(200);
    chk("t3_count", rlog.size(), 4);
    for (int i = 0; i < rlog.size() && i < 4; i++) begin
      chk("t3_tie_class", rlog[i].cls, 1);
      chk("t3_tie_votes", rlog[i].votes, 2);
    end

    // num_samples 0 behaves as one sample
    cfg(2, 0, 0);
    pulse_start();
    wait_idle(200);
    chk("t3b_count", rlog.size(), 4);
    for (int i = 0; i < rlog.size() && i < 4; i++) chk("t3b_votes", rlog[i].votes, 1);

    // Interval 3, two samples
    net_mode = 0; cfg(2, 2, 3);
    pulse_start();
    wait_idle(200);
    chk("t4_count", rlog.size(), 4);
    if (rlog.size() >= 2) begin
      chk("t4_first", rlog[0].cyc - acc_cyc, 9);
      chk("t4_period", rlog[1].cyc - rlog[0].cyc, 8);
    end

    // Abort during char 2 settle, with an ignored mid-sweep start
    cfg(2, 3, 0);
    pulse_start();
    goto_cycle(acc_cyc + 4);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    goto_cycle(acc_cyc + 13);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    repeat (10) @(negedge clk);
    chk("t5_count", rlog.size(), 2);
    if (rlog.size() >= 2) chk("t5_second_cycle", rlog[1].cyc - acc_cyc, 13);
    chk("t5_mask", bus.match_mask, 4'b0011);

    // Start and abort together while idle
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("t5b_busy", bus.busy, 0);

    // Reset during char 1 SAMPLE
    bus.manual_char_select = 2'd3;
    pulse_start();
    goto_cycle(acc_cyc + 9);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", bus.busy, 0);
    chk("t6_char_select", bus.char_select, 3);
    chk("t6_mask", bus.match_mask, 0);
    chk("t6_votes", bus.result_votes, 0);
    rst = 1'b0;
    @(negedge clk);

    // Randomized sweeps with sporadic start/abort/reset and config churn
    for (int s = 0; s < 30; s++) begin
      int n;
      cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3));
      net_mode = $urandom_range(0, 3);
      net_fixed = 2'($urandom_range(0, 3));
      bus.manual_char_select = 2'($urandom_range(0, 3));
      pulse_start();
      n = 0;
      while (bus.busy && n < 3000) begin
        bus.start = ($urandom_range(0, 49) == 0);
        bus.abort = ($urandom_range(0, 299) == 0);
        rst       = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 19) == 0)
          cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3));
        @(negedge clk);
        n++;
      end
      bus.start = 1'b0; bus.abort = 1'b0; rst = 1'b0;
      if (bus.busy) begin
        n_checks++; n_err++;
        $display("FAIL random_timeout: busy %0d after %0d cycles, required 0", bus.busy, n);
      end
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end
endmodule
